// File: rtl/hex_disp_pkg.sv
// Shared segment table, converter FSM encoding and nibble-to-segment lookup
// for the hex display driver.
package hex_disp_pkg;

  // Active-low segments, g in bit 6; entry n is the glyph for nibble n.
  localparam logic [15:0][6:0] SegHex = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h18, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  localparam logic [6:0] SegBlank = 7'h7F;
  localparam logic [6:0] SegDash  = 7'h3F;

  typedef enum logic [1:0] {StIdle, StConv, StDone} conv_state_e;

  function automatic logic [6:0] seg_of(input logic [3:0] nib);
    return SegHex[nib];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, sticky overflow when a
// set bit leaves the top BCD nibble.
module bin2bcd_seq
  import hex_disp_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_W-1:0]       bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    ovf
);

  localparam int unsigned BcdW = 4 * NUM_DIGITS;
  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  conv_state_e         state_q, state_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic [BcdW-1:0]     bcd_q, bcd_d, adj;
  logic                ovf_q, ovf_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StConv;
      StConv:  if (cnt_q == CntW'(DATA_W - 1)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    sh_d  = sh_q;
    bcd_d = bcd_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          sh_d  = bin;
          bcd_d = '0;
          ovf_d = 1'b0;
          cnt_d = '0;
        end
      end
      StConv: begin
        bcd_d = {adj[BcdW-2:0], sh_q[DATA_W-1]};
        sh_d  = sh_q << 1;
        ovf_d = ovf_q | adj[BcdW-1];
        cnt_d = cnt_q + CntW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q  <= '0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      bcd_q <= bcd_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

  assign bcd = bcd_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/hex_display_driver.sv
// N-digit 7-segment driver: latches a value in hex or decimal, then applies
// overflow dashes, leading-zero blanking and per-digit blink to a registered output.
module hex_display_driver
  import hex_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned BLINK_DIV  = 25_000_000
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    load,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    mode,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic                    busy,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] hex_out
);

  localparam int unsigned BcdW   = 4 * NUM_DIGITS;
  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic                    eng_busy, eng_done, eng_ovf;
  logic [BcdW-1:0]         eng_bcd;
  logic                    accept, hex_load, dec_start;
  logic [BcdW-1:0]         hex_pad;
  logic                    hex_ovf;
  logic [BcdW-1:0]         digits_q;
  logic                    valid_q, overflow_q;
  logic [BlinkW-1:0]       blink_cnt_q;
  logic                    phase_q;
  logic [NUM_DIGITS-1:0]   lz;
  logic                    seen;
  logic [6:0]              seg;
  logic [7*NUM_DIGITS-1:0] hex_out_d, hex_out_q;

  assign accept    = load & ~eng_busy;
  assign hex_load  = accept & ~mode;
  assign dec_start = accept & mode;

  bin2bcd_seq #(
    .DATA_W     (DATA_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk   (CLOCK_50),
    .reset (reset),
    .start (dec_start),
    .bin   (data_in),
    .busy  (eng_busy),
    .done  (eng_done),
    .bcd   (eng_bcd),
    .ovf   (eng_ovf)
  );

  // Zero-extend into the digit field; anything above it is overflow.
  always_comb begin
    hex_pad = '0;
    hex_ovf = 1'b0;
    for (int i = 0; i < int'(BcdW); i++) begin
      if (i < int'(DATA_W)) hex_pad[i] = data_in[i];
    end
    for (int i = int'(BcdW); i < int'(DATA_W); i++) begin
      hex_ovf = hex_ovf | data_in[i];
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      digits_q   <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (hex_load) begin
      digits_q   <= hex_pad;
      valid_q    <= 1'b1;
      overflow_q <= hex_ovf;
    end else if (eng_done) begin
      digits_q   <= eng_bcd;
      valid_q    <= 1'b1;
      overflow_q <= eng_ovf;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (blink_cnt_q == BlinkW'(BLINK_DIV - 1)) begin
      blink_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BlinkW'(1);
    end
  end

  // Digit 0 is excluded so a zero value still shows one '0'.
  always_comb begin
    seen = 1'b0;
    lz   = '0;
    for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
      if (digits_q[4*i +: 4] != 4'd0) seen = 1'b1;
      lz[i] = ~seen;
    end
  end

  always_comb begin
    hex_out_d = '1;
    seg       = SegBlank;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      seg = SegBlank;
      if (valid_q) begin
        seg = overflow_q ? SegDash : seg_of(digits_q[4*i +: 4]);
        if ((blank_lz && lz[i]) || (blink_mask[i] && phase_q)) seg = SegBlank;
      end
      hex_out_d[7*i +: 7] = seg;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) hex_out_q <= '1;
    else       hex_out_q <= hex_out_d;
  end

  assign busy     = eng_busy;
  assign overflow = overflow_q;
  assign hex_out  = hex_out_q;

endmodule
